// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: two-port fixed-priority arbiter with starvation relief and watchdog for one scratchpad port
module scratchpad_arbiter #(
    parameter int XLEN           = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        rq_req,
    input  logic [1:0]        rq_we,
    input  logic [2*XLEN-1:0] rq_addr,
    input  logic [2*XLEN-1:0] rq_wdata,
    output logic [1:0]        rq_ready,
    output logic [XLEN-1:0]   rq_rdata,
    output logic              rq_error,
    output logic              sp_req,
    output logic              sp_we,
    output logic [XLEN-1:0]   sp_addr,
    output logic [XLEN-1:0]   sp_wdata,
    input  logic              sp_ready,
    input  logic [XLEN-1:0]   sp_rdata,
    input  logic              sp_error,
    output logic              grant_id,
    output logic              arb_busy,
    output logic              arb_timeout
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_n;
    logic [SW-1:0]     starve_cnt, starve_n;
    logic [WW-1:0]     wd_cnt, wd_n;
    logic [1:0]        rq_ready_n;
    logic [XLEN-1:0]   rq_rdata_n, sp_addr_n, sp_wdata_n;
    logic              rq_error_n, sp_req_n, sp_we_n, grant_n, busy_n, timeout_n;
    logic              win1;

    assign win1 = rq_req[1] && (!rq_req[0] || starve_cnt == SW'(STARVE_LIMIT));

    // next-state and next-output computation; every output is then registered
    always_comb begin
        state_n    = state;
        starve_n   = starve_cnt;
        wd_n       = wd_cnt;
        rq_ready_n = '0;
        rq_rdata_n = rq_rdata;
        rq_error_n = rq_error;
        sp_req_n   = sp_req;
        sp_we_n    = sp_we;
        sp_addr_n  = sp_addr;
        sp_wdata_n = sp_wdata;
        grant_n    = grant_id;
        timeout_n  = 1'b0;
        case (state)
            IDLE: if (|rq_req) begin
                state_n    = BUSY;
                grant_n    = win1;
                sp_req_n   = 1'b1;
                sp_we_n    = rq_we[win1];
                sp_addr_n  = rq_addr[win1*XLEN +: XLEN];
                sp_wdata_n = rq_wdata[win1*XLEN +: XLEN];
                wd_n       = '0;
                starve_n   = (win1 || !rq_req[1]) ? '0 :
                             (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
            end
            BUSY: begin
                wd_n = wd_cnt + 1'b1;
                if (sp_ready || wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_n              = RESP;
                    sp_req_n             = 1'b0;
                    wd_n                 = '0;
                    rq_ready_n[grant_id] = 1'b1;
                    rq_rdata_n           = sp_ready ? sp_rdata : '0;
                    rq_error_n           = sp_ready ? sp_error : 1'b1;
                    timeout_n            = !sp_ready;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            rq_ready    <= '0;
            rq_rdata    <= '0;
            rq_error    <= 1'b0;
            sp_req      <= 1'b0;
            sp_we       <= 1'b0;
            sp_addr     <= '0;
            sp_wdata    <= '0;
            grant_id    <= 1'b0;
            arb_busy    <= 1'b0;
            arb_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            starve_cnt  <= starve_n;
            wd_cnt      <= wd_n;
            rq_ready    <= rq_ready_n;
            rq_rdata    <= rq_rdata_n;
            rq_error    <= rq_error_n;
            sp_req      <= sp_req_n;
            sp_we       <= sp_we_n;
            sp_addr     <= sp_addr_n;
            sp_wdata    <= sp_wdata_n;
            grant_id    <= grant_n;
            arb_busy    <= busy_n;
            arb_timeout <= timeout_n;
        end
    end
endmodule

// File: tb/tb_scratchpad_arbiter.sv
// tb_scratchpad_arbiter: directed scenario tests for scratchpad_arbiter
module tb_scratchpad_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      rq_req, rq_we, rq_ready;
    logic [63:0]     rq_addr, rq_wdata;
    logic [31:0]     rq_rdata, sp_addr, sp_wdata, sp_rdata;
    logic            rq_error, sp_req, sp_we, sp_ready, sp_error, grant_id, arb_busy, arb_timeout;
    int              n_cmp = 0;
    int              n_err = 0;

    scratchpad_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_ready(rq_ready), .rq_rdata(rq_rdata), .rq_error(rq_error),
        .sp_req(sp_req), .sp_we(sp_we), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
        .sp_ready(sp_ready), .sp_rdata(sp_rdata), .sp_error(sp_error), .grant_id(grant_id),
        .arb_busy(arb_busy), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    // advance one cycle; outputs are settled and inputs may be changed afterwards
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; rq_req = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0;
        sp_ready = 1'b0; sp_rdata = '0; sp_error = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({sp_req, arb_busy, arb_timeout, rq_error, grant_id} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {sp_req, arb_busy, arb_timeout, rq_error, grant_id}); end
        n_cmp++; if (rq_ready !== 2'b00) begin n_err++; $display("FAIL reset_rq_ready got %b want 00", rq_ready); end
        n_cmp++; if (rq_rdata !== 32'h0 || sp_addr !== 32'h0) begin n_err++; $display("FAIL reset_data got rdata=%h addr=%h want 0/0", rq_rdata, sp_addr); end
    endtask

    task automatic test_single_read();
        rq_req = 2'b01; rq_we = 2'b00; rq_addr = {32'h0, 32'h100};
        tick();
        n_cmp++; if ({sp_req, sp_we, grant_id, arb_busy} !== 4'b1001) begin n_err++; $display("FAIL t1_grant got req/we/gid/busy=%b want 1001", {sp_req, sp_we, grant_id, arb_busy}); end
        n_cmp++; if (sp_addr !== 32'h100) begin n_err++; $display("FAIL t1_sp_addr got %h want 00000100", sp_addr); end
        tick();
        sp_ready = 1'b1; sp_rdata = 32'hCAFE0001;
        tick();
        sp_ready = 1'b0; rq_req = 2'b00;
        n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL t1_rq_ready got %b want 01", rq_ready); end
        n_cmp++; if (rq_rdata !== 32'hCAFE0001 || rq_error !== 1'b0) begin n_err++; $display("FAIL t1_rdata got %h err=%b want cafe0001 err=0", rq_rdata, rq_error); end
        n_cmp++; if (sp_req !== 1'b0 || arb_busy !== 1'b1) begin n_err++; $display("FAIL t1_resp got sp_req=%b busy=%b want 0/1", sp_req, arb_busy); end
        tick();
        n_cmp++; if (rq_ready !== 2'b00 || arb_busy !== 1'b0 || rq_rdata !== 32'hCAFE0001) begin n_err++; $display("FAIL t1_idle got ready=%b busy=%b rdata=%h want 00/0/cafe0001", rq_ready, arb_busy, rq_rdata); end
    endtask

    task automatic test_priority();
        rq_req = 2'b11; rq_we = 2'b01;
        rq_addr = {32'h300, 32'h200}; rq_wdata = {32'h0, 32'h11};
        tick();
        n_cmp++; if ({sp_we, grant_id} !== 2'b10 || sp_addr !== 32'h200 || sp_wdata !== 32'h11) begin n_err++; $display("FAIL t2_port0 got we=%b gid=%b addr=%h wdata=%h want 1/0/200/11", sp_we, grant_id, sp_addr, sp_wdata); end
        sp_ready = 1'b1; sp_rdata = 32'h5;
        tick();
        sp_ready = 1'b0; rq_req = 2'b10;
        n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL t2_ready0 got %b want 01", rq_ready); end
        tick();
        tick();
        n_cmp++; if ({sp_req, sp_we, grant_id} !== 3'b101 || sp_addr !== 32'h300) begin n_err++; $display("FAIL t2_port1 got req/we/gid=%b addr=%h want 101/300", {sp_req, sp_we, grant_id}, sp_addr); end
        sp_ready = 1'b1; sp_rdata = 32'h77;
        tick();
        sp_ready = 1'b0; rq_req = 2'b00;
        n_cmp++; if (rq_ready !== 2'b10 || rq_rdata !== 32'h77) begin n_err++; $display("FAIL t2_ready1 got %b rdata=%h want 10/77", rq_ready, rq_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] got = '0;
        logic [9:0] want = 10'b10000_10000;
        do_reset();
        rq_req = 2'b11; rq_we = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            got[i] = grant_id;
            sp_ready = 1'b1;
            tick();
            sp_ready = 1'b0;
            tick();
        end
        rq_req = 2'b00;
        n_cmp++; if (got !== want) begin n_err++; $display("FAIL t3_order got %b want %b (bit0 first)", got, want); end
    endtask

    task automatic test_timeout();
        rq_req = 2'b01; rq_we = 2'b00; rq_addr = {32'h0, 32'h400};
        tick();
        rq_req = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (sp_req !== 1'b1 || arb_timeout !== 1'b0 || rq_ready !== 2'b00) begin n_err++; $display("FAIL t4_still_busy got req=%b to=%b ready=%b want 1/0/00", sp_req, arb_timeout, rq_ready); end
        tick();
        n_cmp++; if (rq_ready !== 2'b01 || arb_timeout !== 1'b1) begin n_err++; $display("FAIL t4_abort got ready=%b to=%b want 01/1", rq_ready, arb_timeout); end
        n_cmp++; if (rq_error !== 1'b1 || rq_rdata !== 32'h0 || sp_req !== 1'b0) begin n_err++; $display("FAIL t4_abort_data got err=%b rdata=%h req=%b want 1/0/0", rq_error, rq_rdata, sp_req); end
        sp_ready = 1'b1; sp_rdata = 32'hDEAD; sp_error = 1'b0;
        tick();
        sp_ready = 1'b0;
        n_cmp++; if (rq_ready !== 2'b00 || arb_timeout !== 1'b0 || arb_busy !== 1'b0) begin n_err++; $display("FAIL t4_after got ready=%b to=%b busy=%b want 00/0/0", rq_ready, arb_timeout, arb_busy); end
        tick();
        n_cmp++; if (rq_rdata !== 32'h0 || rq_error !== 1'b1 || sp_req !== 1'b0) begin n_err++; $display("FAIL t4_late_ack got rdata=%h err=%b req=%b want 0/1/0", rq_rdata, rq_error, sp_req); end
    endtask

    task automatic test_sp_error();
        rq_req = 2'b10; rq_we = 2'b00; rq_addr = {32'h500, 32'h0};
        tick();
        n_cmp++; if (grant_id !== 1'b1 || sp_addr !== 32'h500) begin n_err++; $display("FAIL t5_grant got gid=%b addr=%h want 1/500", grant_id, sp_addr); end
        sp_ready = 1'b1; sp_error = 1'b1; sp_rdata = 32'h1234;
        tick();
        sp_ready = 1'b0; sp_error = 1'b0; rq_req = 2'b00;
        n_cmp++; if (rq_ready !== 2'b10 || rq_error !== 1'b1 || arb_timeout !== 1'b0) begin n_err++; $display("FAIL t5_err got ready=%b err=%b to=%b want 10/1/0", rq_ready, rq_error, arb_timeout); end
        tick();
    endtask

    task automatic test_async_reset();
        rq_req = 2'b01; rq_addr = {32'h0, 32'h600};
        tick();
        rq_req = 2'b00;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (sp_req !== 1'b0 || arb_busy !== 1'b0 || rq_ready !== 2'b00) begin n_err++; $display("FAIL t6_async got req=%b busy=%b ready=%b want 0/0/00", sp_req, arb_busy, rq_ready); end
        sp_ready = 1'b1;
        tick();
        sp_ready = 1'b0;
        n_cmp++; if (rq_ready !== 2'b00) begin n_err++; $display("FAIL t6_no_pulse got %b want 00", rq_ready); end
        reset_n = 1'b1;
        rq_req = 2'b10; rq_we = 2'b00; rq_addr = {32'h700, 32'h0};
        tick();
        n_cmp++; if ({sp_req, grant_id} !== 2'b11 || sp_addr !== 32'h700) begin n_err++; $display("FAIL t6_regrant got req/gid=%b addr=%h want 11/700", {sp_req, grant_id}, sp_addr); end
        sp_ready = 1'b1; sp_rdata = 32'hBEEF;
        tick();
        sp_ready = 1'b0; rq_req = 2'b00;
        n_cmp++; if (rq_ready !== 2'b10 || rq_rdata !== 32'hBEEF) begin n_err++; $display("FAIL t6_done got ready=%b rdata=%h want 10/beef", rq_ready, rq_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_starvation();
        test_timeout();
        test_sp_error();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
